// File: rtl/band_demux_1to16_if.sv
// Bundles the band-word stream and the parallel band bank of band_demux_1to16.
// The source side (master) drives the stream; the demux (slave) drives the bank and status.
interface band_demux_1to16_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] data0,  data1,  data2,  data3;
    logic [DATA_W-1:0] data4,  data5,  data6,  data7;
    logic [DATA_W-1:0] data8,  data9,  data10, data11;
    logic [DATA_W-1:0] data12, data13, data14, data15;
    logic [3:0]        index;
    logic              frame_valid;
    logic              sync_err;
    logic [7:0]        frame_cnt;

    modport master (
        output in_data, in_valid, in_sof,
        input  data0, data1, data2, data3, data4, data5, data6, data7,
        input  data8, data9, data10, data11, data12, data13, data14, data15,
        input  index, frame_valid, sync_err, frame_cnt
    );

    modport slave (
        input  in_data, in_valid, in_sof,
        output data0, data1, data2, data3, data4, data5, data6, data7,
        output data8, data9, data10, data11, data12, data13, data14, data15,
        output index, frame_valid, sync_err, frame_cnt
    );
endinterface

// File: rtl/band_demux_1to16.sv
// Distributes a push-only stream of band words into a 16-band register bank.
// BAND_DEMUX_DBUF_EN: shadow bank + output bank that loads only on a complete frame.
//
// state | meaning
// IDLE  | waiting for start-of-frame; non-SOF words are dropped
// FILL  | frame in progress; index points at the next band to write
module band_demux_1to16 #(
    parameter int DATA_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    band_demux_1to16_if.slave     bus
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [3:0]        index_q, index_d;
    logic [7:0]        frame_cnt_q;
    logic              frame_valid_q;
    logic              sync_err_q;
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic              commit;
    logic              sync_err_d;
    logic [DATA_W-1:0] band_q [16];
    logic [DATA_W-1:0] out_bank [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            index_q       <= 4'd0;
            frame_cnt_q   <= 8'd0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            frame_valid_q <= commit;
            sync_err_q    <= sync_err_d;
            if (commit) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        wr_en      = 1'b0;
        wr_idx     = 4'd0;
        commit     = 1'b0;
        sync_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_sof) begin
                    wr_en   = 1'b1;
                    index_d = 4'd1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.in_valid) begin
                    wr_en = 1'b1;
                    if (bus.in_sof) begin
                        // Premature SOF restarts the frame in place; stale bands stay.
                        sync_err_d = 1'b1;
                        index_d    = 4'd1;
                    end else begin
                        wr_idx = index_q;
                        if (index_q == 4'd15) begin
                            index_d = 4'd0;
                            commit  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            index_d = index_q + 4'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                index_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) band_q[k] <= '0;
        end else if (wr_en) begin
            band_q[wr_idx] <= bus.in_data;
        end
    end

`ifdef BAND_DEMUX_DBUF_EN
    logic [DATA_W-1:0] out_q [16];

    // Band 15 is taken straight from the input so the whole frame lands on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) out_q[k] <= '0;
        end else if (commit) begin
            for (int k = 0; k < 15; k++) out_q[k] <= band_q[k];
            out_q[15] <= bus.in_data;
        end
    end

    assign out_bank = out_q;
`else
    assign out_bank = band_q;
`endif

    assign bus.data0       = out_bank[0];
    assign bus.data1       = out_bank[1];
    assign bus.data2       = out_bank[2];
    assign bus.data3       = out_bank[3];
    assign bus.data4       = out_bank[4];
    assign bus.data5       = out_bank[5];
    assign bus.data6       = out_bank[6];
    assign bus.data7       = out_bank[7];
    assign bus.data8       = out_bank[8];
    assign bus.data9       = out_bank[9];
    assign bus.data10      = out_bank[10];
    assign bus.data11      = out_bank[11];
    assign bus.data12      = out_bank[12];
    assign bus.data13      = out_bank[13];
    assign bus.data14      = out_bank[14];
    assign bus.data15      = out_bank[15];
    assign bus.index       = index_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_band_demux_1to16.sv
// Bench for band_demux_1to16: directed scenarios plus random traffic against a frame-level model.
module tb_band_demux_1to16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    band_demux_1to16_if #(.DATA_W(12)) bif ();
    band_demux_1to16 #(.DATA_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    logic [11:0] dout [16];
    assign dout[0]  = bif.data0;   assign dout[1]  = bif.data1;
    assign dout[2]  = bif.data2;   assign dout[3]  = bif.data3;
    assign dout[4]  = bif.data4;   assign dout[5]  = bif.data5;
    assign dout[6]  = bif.data6;   assign dout[7]  = bif.data7;
    assign dout[8]  = bif.data8;   assign dout[9]  = bif.data9;
    assign dout[10] = bif.data10;  assign dout[11] = bif.data11;
    assign dout[12] = bif.data12;  assign dout[13] = bif.data13;
    assign dout[14] = bif.data14;  assign dout[15] = bif.data15;

    int n_cmp = 0;
    int n_fail = 0;

    // Frame-level model: words collected since the last SOF, plus the visible bank.
    logic [11:0] m_shadow [16];
    logic [11:0] m_out [16];
    int          m_pos;
    bit          m_in_frame;
    int          m_cnt;
    bit          m_fv, m_se;
    int          fv_seen, se_seen, pulse_bad;

    function automatic logic [11:0] exp_data(input int k);
`ifdef BAND_DEMUX_DBUF_EN
        return m_out[k];
`else
        return m_shadow[k];
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin m_shadow[k] = '0; m_out[k] = '0; end
        m_pos = 0; m_in_frame = 0; m_cnt = 0; m_fv = 0; m_se = 0;
    endtask

    task automatic model_beat(input bit v, input bit s, input logic [11:0] d);
        m_fv = 0; m_se = 0;
        if (!v) return;
        if (s) begin
            m_se = m_in_frame;
            m_in_frame = 1;
            m_shadow[0] = d;
            m_pos = 1;
        end else if (m_in_frame) begin
            m_shadow[m_pos] = d;
            m_pos++;
            if (m_pos == 16) begin
                m_pos = 0; m_in_frame = 0; m_fv = 1;
                m_cnt = (m_cnt + 1) % 256;
                for (int k = 0; k < 16; k++) m_out[k] = m_shadow[k];
            end
        end
    endtask

    // One clock of stimulus; records observed pulses versus the model.
    task automatic beat(input bit v, input bit s, input logic [11:0] d);
        @(negedge clk);
        bif.in_valid = v; bif.in_sof = s; bif.in_data = d;
        @(posedge clk);
        model_beat(v, s, d);
        #1;
        if (bif.frame_valid !== m_fv || bif.sync_err !== m_se) pulse_bad++;
        fv_seen += int'(bif.frame_valid);
        se_seen += int'(bif.sync_err);
        bif.in_valid = 1'b0; bif.in_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] base, input int gap);
        for (int k = 0; k < 16; k++) begin
            beat(1'b1, k == 0, base + 12'(k));
            for (int g = 0; g < gap && k < 15; g++) beat(1'b0, 1'b0, 12'hEEE);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (dout[k] !== 12'h000) begin n_fail++; $display("FAIL reset_data%0d got %h want 000", k, dout[k]); end
        end
        n_cmp++;
        if (bif.index !== 4'd0 || bif.frame_valid !== 1'b0 || bif.sync_err !== 1'b0 || bif.frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_status got idx=%0d fv=%b se=%b cnt=%0d want 0/0/0/0",
                     bif.index, bif.frame_valid, bif.sync_err, bif.frame_cnt);
        end
    endtask

    task automatic test_basic();
        fv_seen = 0; pulse_bad = 0;
        send_frame(12'h100, 0);
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (dout[k] !== 12'h100 + 12'(k)) begin n_fail++; $display("FAIL basic_data%0d got %h want %h", k, dout[k], 12'h100 + 12'(k)); end
        end
        n_cmp++;
        if (bif.frame_cnt !== 8'd1 || bif.index !== 4'd0) begin
            n_fail++; $display("FAIL basic_status got cnt=%0d idx=%0d want 1/0", bif.frame_cnt, bif.index);
        end
        n_cmp++;
        if (fv_seen !== 1 || pulse_bad !== 0) begin
            n_fail++; $display("FAIL basic_pulse got fv_seen=%0d bad=%0d want 1/0", fv_seen, pulse_bad);
        end
    endtask

    task automatic test_idle_drop();
        do_reset();
        fv_seen = 0; se_seen = 0; pulse_bad = 0;
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 12'hAAA);
        beat(1'b0, 1'b1, 12'h555);
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (dout[k] !== 12'h000) begin n_fail++; $display("FAIL drop_data%0d got %h want 000", k, dout[k]); end
        end
        n_cmp++;
        if (bif.index !== 4'd0 || fv_seen !== 0 || se_seen !== 0) begin
            n_fail++; $display("FAIL drop_status got idx=%0d fv=%0d se=%0d want 0/0/0", bif.index, fv_seen, se_seen);
        end
        send_frame(12'h040, 0);
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (dout[k] !== 12'h040 + 12'(k)) begin n_fail++; $display("FAIL drop_frame_data%0d got %h want %h", k, dout[k], 12'h040 + 12'(k)); end
        end
        n_cmp++;
        if (bif.frame_cnt !== 8'd1 || fv_seen !== 1) begin
            n_fail++; $display("FAIL drop_frame_cnt got cnt=%0d fv=%0d want 1/1", bif.frame_cnt, fv_seen);
        end
    endtask

    task automatic test_premature();
        logic [7:0] cnt0;
        send_frame(12'h200, 0);
        cnt0 = bif.frame_cnt;
        fv_seen = 0; se_seen = 0; pulse_bad = 0;
        for (int k = 0; k < 5; k++) beat(1'b1, k == 0, 12'h300 + 12'(k));
        beat(1'b1, 1'b1, 12'h3FF);
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (dout[k] !== exp_data(k)) begin n_fail++; $display("FAIL premature_data%0d got %h want %h", k, dout[k], exp_data(k)); end
        end
`ifdef BAND_DEMUX_DBUF_EN
        n_cmp++;
        if (dout[0] !== 12'h200 || dout[5] !== 12'h205) begin
            n_fail++; $display("FAIL premature_outputs_held got %h/%h want 200/205", dout[0], dout[5]);
        end
`else
        n_cmp++;
        if (dout[0] !== 12'h3FF || dout[4] !== 12'h304 || dout[5] !== 12'h205) begin
            n_fail++; $display("FAIL premature_bank got %h/%h/%h want 3ff/304/205", dout[0], dout[4], dout[5]);
        end
`endif
        n_cmp++;
        if (se_seen !== 1 || fv_seen !== 0 || pulse_bad !== 0 || bif.index !== 4'd1 || bif.frame_cnt !== cnt0) begin
            n_fail++; $display("FAIL premature_status got se=%0d fv=%0d bad=%0d idx=%0d cnt=%0d want 1/0/0/1/%0d",
                               se_seen, fv_seen, pulse_bad, bif.index, bif.frame_cnt, cnt0);
        end
        for (int k = 1; k < 16; k++) beat(1'b1, 1'b0, 12'h3F0 + 12'(k));
        n_cmp++;
        if (fv_seen !== 1 || bif.frame_cnt !== 8'(cnt0 + 8'd1) || dout[15] !== 12'h3FF) begin
            n_fail++; $display("FAIL premature_recover got fv=%0d cnt=%0d d15=%h want 1/%0d/3ff",
                               fv_seen, bif.frame_cnt, dout[15], cnt0 + 8'd1);
        end
    endtask

    task automatic test_gaps();
        fv_seen = 0; pulse_bad = 0;
        send_frame(12'h500, 2);
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (dout[k] !== 12'h500 + 12'(k)) begin n_fail++; $display("FAIL gaps_data%0d got %h want %h", k, dout[k], 12'h500 + 12'(k)); end
        end
        n_cmp++;
        if (fv_seen !== 1 || pulse_bad !== 0 || bif.frame_cnt !== 8'(m_cnt)) begin
            n_fail++; $display("FAIL gaps_pulse got fv=%0d bad=%0d cnt=%0d want 1/0/%0d", fv_seen, pulse_bad, bif.frame_cnt, m_cnt);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 8; k++) beat(1'b1, k == 0, 12'h600 + 12'(k));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (dout[k] !== 12'h000) begin n_fail++; $display("FAIL async_rst_data%0d got %h want 000", k, dout[k]); end
        end
        n_cmp++;
        if (bif.index !== 4'd0 || bif.frame_cnt !== 8'd0) begin
            n_fail++; $display("FAIL async_rst_status got idx=%0d cnt=%0d want 0/0", bif.index, bif.frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fv_seen = 0;
        beat(1'b1, 1'b0, 12'h777);
        send_frame(12'h700, 0);
        n_cmp++;
        if (bif.frame_cnt !== 8'd1 || fv_seen !== 1 || dout[15] !== 12'h70F) begin
            n_fail++; $display("FAIL async_rst_refill got cnt=%0d fv=%0d d15=%h want 1/1/70f", bif.frame_cnt, fv_seen, dout[15]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        fv_seen = 0; pulse_bad = 0;
        for (int f = 0; f < 257; f++) send_frame(12'($urandom_range(0, 4095)), 0);
        n_cmp++;
        if (bif.frame_cnt !== 8'd1 || fv_seen !== 257 || pulse_bad !== 0) begin
            n_fail++; $display("FAIL wrap_cnt got cnt=%0d fv=%0d bad=%0d want 1/257/0", bif.frame_cnt, fv_seen, pulse_bad);
        end
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (dout[k] !== exp_data(k)) begin n_fail++; $display("FAIL wrap_data%0d got %h want %h", k, dout[k], exp_data(k)); end
        end
    endtask

    task automatic test_random();
        bit v, s;
        int bad_beats = 0;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 13) == 0);
            pulse_bad = 0;
            beat(v, s, 12'($urandom_range(0, 4095)));
            n_cmp++;
            if (pulse_bad !== 0 || bif.index !== 4'(m_pos) || bif.frame_cnt !== 8'(m_cnt)) begin
                n_fail++; bad_beats++;
                if (bad_beats <= 5)
                    $display("FAIL random_beat%0d got idx=%0d cnt=%0d fv=%b se=%b want %0d/%0d/%b/%b",
                             i, bif.index, bif.frame_cnt, bif.frame_valid, bif.sync_err, m_pos, m_cnt, m_fv, m_se);
            end
            for (int k = 0; k < 16; k++) begin
                if (dout[k] !== exp_data(k)) begin
                    n_cmp++; n_fail++;
                    $display("FAIL random_data%0d beat %0d got %h want %h", k, i, dout[k], exp_data(k));
                end
            end
        end
    endtask

    initial begin
        bif.in_valid = 1'b0; bif.in_sof = 1'b0; bif.in_data = '0;
        fv_seen = 0; se_seen = 0; pulse_bad = 0;
        model_reset();
        test_reset();
        test_basic();
        test_idle_drop();
        test_premature();
        test_gaps();
        test_async_reset();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
